// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one Booth group per clock.
// Per-operand signed/unsigned mode. Valid/ready handshake on input and output.
// Optional macro BOOTH_MUL_EARLY_EXIT_EN: finish as soon as every remaining
// multiplier group would contribute a zero partial product.
module booth_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic               op1_signed,
  input  logic               op2_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               busy
);

  // One extra group beyond WIDTH/2 covers zero-extended full-width unsigned operands
  localparam int N = WIDTH/2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH+1:0]   mplr;
  logic               lb;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH+1:0]   mplr_nxt;
  logic               lb_nxt;
  logic               last_step;

  // Partial product selection from the current Booth group and next-state values
  always_comb begin
    pp = '0;
    case ({mplr[1:0], lb})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    acc_nxt  = acc + pp;
    mplr_nxt = {{2{mplr[WIDTH+1]}}, mplr[WIDTH+1:2]};
    lb_nxt   = mplr[1];
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    last_step = (cnt == LAST) || (&{mplr_nxt, lb_nxt}) || !(|{mplr_nxt, lb_nxt});
`else
    last_step = (cnt == LAST);
`endif
  end

  // Control FSM and datapath registers, outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
      acc       <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      lb        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= op1_signed ? {{WIDTH{op1[WIDTH-1]}}, op1} : {{WIDTH{1'b0}}, op1};
            mplr     <= {{2{op2_signed & op2[WIDTH-1]}}, op2};
            lb       <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          mcand <= mcand << 2;
          mplr  <= mplr_nxt;
          lb    <= lb_nxt;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            res       <= acc_nxt;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
